// File: rtl/ad9361_tx_burst_gate_pkg.sv
// ad9361_tx_burst_gate_pkg
// Shared definitions for the AD9361 TX burst gate: channel count, sample
// type, FSM state encodings (3-bit, legacy-compatible) and the gain width
// helper used to size the ramp gain bus.
package ad9361_tx_burst_gate_pkg;

  localparam int unsigned NCH    = 4;
  localparam int unsigned SAMP_W = 12;

  typedef logic signed [SAMP_W-1:0] samp_t;

  // state     | meaning
  // S_IDLE    | no burst, zeros on every tick, tx_active low
  // S_LEAD    | PA settling zeros, tx_active high
  // S_RAMP_UP | popping payload, gain rising 0..N-1
  // S_ON      | popping payload at unity gain
  // S_RAMP_DOWN | replaying held sample, gain falling N-1..0
  // S_TAIL    | trailing zeros before tx_active drops
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LEAD      = 3'd1;
  localparam logic [2:0] S_RAMP_UP   = 3'd2;
  localparam logic [2:0] S_ON        = 3'd3;
  localparam logic [2:0] S_RAMP_DOWN = 3'd4;
  localparam logic [2:0] S_TAIL      = 3'd5;

  // Gain must reach N = 2^log2_len exactly, so it needs one extra bit.
  function automatic int unsigned gain_width(input int unsigned log2_len);
    return log2_len + 1;
  endfunction

endpackage

// File: rtl/ad9361_tx_burst_gate_if.sv
// ad9361_tx_burst_gate_if
// Groups the packetised input stream and the DAC-rate output stream.
//   in_valid/in_ready/in_last  input handshake, in_last marks final payload
//   data_i_in/data_q_in        4 channels of signed 12-bit I/Q payload
//   valid_out                  one-cycle strobe per emitted sample
//   data_i_out/data_q_out      4 channels of signed 12-bit I/Q output
// master: upstream source / downstream sink side. slave: the burst gate.
interface ad9361_tx_burst_gate_if;
  import ad9361_tx_burst_gate_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic                in_last;
  samp_t [NCH-1:0]     data_i_in;
  samp_t [NCH-1:0]     data_q_in;
  logic                valid_out;
  samp_t [NCH-1:0]     data_i_out;
  samp_t [NCH-1:0]     data_q_out;

  modport master (
    output in_valid, in_last, data_i_in, data_q_in,
    input  in_ready, valid_out, data_i_out, data_q_out
  );

  modport slave (
    input  in_valid, in_last, data_i_in, data_q_in,
    output in_ready, valid_out, data_i_out, data_q_out
  );

endinterface

// File: rtl/ad9361_tx_burst_gate_ramp_mul.sv
// ad9361_tx_ramp_mul
// Scales one I/Q pair by an unsigned gain g: out = (x * g) >>> LOG2_RAMP_LEN.
// Two register stages: product (loaded by ld_prod) and shifted output
// (loaded by ld_out). With g = 2^LOG2_RAMP_LEN the result is exactly x.
// Ports: clk, rst_n (async active-low), ld_prod, ld_out, gain,
//        i_in/q_in (signed), i_out/q_out (signed, registered).
module ad9361_tx_ramp_mul
  import ad9361_tx_burst_gate_pkg::*;
#(
  parameter int unsigned LOG2_RAMP_LEN = 3,
  localparam int unsigned GW = gain_width(LOG2_RAMP_LEN),
  localparam int unsigned PW = SAMP_W + GW + 1
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_prod,
  input  logic          ld_out,
  input  logic [GW-1:0] gain,
  input  samp_t         i_in,
  input  samp_t         q_in,
  output samp_t         i_out,
  output samp_t         q_out
);

  logic signed [GW:0]   g_s;
  logic signed [PW-1:0] p_i;
  logic signed [PW-1:0] p_q;
  logic                 unused_bits;

  assign g_s = $signed({1'b0, gain});

  // Selecting bits [LOG2 +: SAMP_W] of the signed product is the arithmetic
  // right shift (floor); |x*g| <= |x|*N keeps the result within SAMP_W.
  assign unused_bits = ^{p_i[LOG2_RAMP_LEN-1:0], p_i[PW-1:LOG2_RAMP_LEN+SAMP_W],
                         p_q[LOG2_RAMP_LEN-1:0], p_q[PW-1:LOG2_RAMP_LEN+SAMP_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_i   <= '0;
      p_q   <= '0;
      i_out <= '0;
      q_out <= '0;
    end else begin
      if (ld_prod) begin
        p_i <= PW'(i_in) * PW'(g_s);
        p_q <= PW'(q_in) * PW'(g_s);
      end
      if (ld_out) begin
        i_out <= p_i[LOG2_RAMP_LEN +: SAMP_W];
        q_out <= p_q[LOG2_RAMP_LEN +: SAMP_W];
      end
    end
  end

endmodule

// File: rtl/ad9361_tx_burst_gate.sv
// ad9361_tx_burst_gate
// Converts a packetised 4-channel I/Q stream into a continuous DAC-rate
// stream, framing each burst as lead zeros, ramp-up, payload, ramp-down,
// tail zeros, and holds tx_active high for the whole framed burst.
// Ports: clk, rst_n (async active-low), samp_en (DAC tick), bus (stream
//        interface, slave side), tx_active, underflow (sticky),
//        burst_count / underflow_count (saturating 16-bit statistics).
// Build option: define AD9361_TX_BURST_STATS_EN to generate the statistics
// counters; otherwise both count ports read 0.
module ad9361_tx_burst_gate
  import ad9361_tx_burst_gate_pkg::*;
#(
  parameter int unsigned LOG2_RAMP_LEN = 3,
  parameter int unsigned LEAD_SAMPLES  = 16,
  parameter int unsigned TAIL_SAMPLES  = 16
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  samp_en,
  ad9361_tx_burst_gate_if.slave bus,
  output logic                  tx_active,
  output logic                  underflow,
  output logic [15:0]           burst_count,
  output logic [15:0]           underflow_count
);

  localparam int unsigned GW = gain_width(LOG2_RAMP_LEN);
  localparam logic [GW-1:0] G_UNITY = {1'b1, {LOG2_RAMP_LEN{1'b0}}};
  localparam logic [LOG2_RAMP_LEN-1:0] K_LAST = '1;

  logic [2:0]               state, state_nxt;
  logic [LOG2_RAMP_LEN-1:0] ramp_k, ramp_nxt;
  logic [15:0]              tick_cnt, tick_nxt;
  logic [GW-1:0]            gain;
  logic                     sel_held;
  logic                     pop;
  logic                     starve;
  logic                     clear_held;
  logic                     v1;
  samp_t [NCH-1:0]          held_i;
  samp_t [NCH-1:0]          held_q;

  assign bus.in_ready = samp_en & ((state == S_RAMP_UP) | (state == S_ON));
  assign tx_active    = (state != S_IDLE);

  // gain stays 0 outside RAMP_UP/ON/RAMP_DOWN, so those ticks emit zeros.
  always_comb begin
    state_nxt  = state;
    ramp_nxt   = ramp_k;
    tick_nxt   = tick_cnt;
    gain       = '0;
    sel_held   = 1'b0;
    pop        = 1'b0;
    starve     = 1'b0;
    clear_held = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_nxt  = S_LEAD;
          tick_nxt   = 16'(LEAD_SAMPLES - 1);
          clear_held = 1'b1;
        end
      end
      S_LEAD: begin
        if (samp_en) begin
          if (tick_cnt == '0) begin
            state_nxt = S_RAMP_UP;
            ramp_nxt  = '0;
          end else begin
            tick_nxt = tick_cnt - 16'd1;
          end
        end
      end
      S_RAMP_UP, S_ON: begin
        if (samp_en) begin
          gain = (state == S_ON) ? G_UNITY : {1'b0, ramp_k};
          if (bus.in_valid) begin
            pop = 1'b1;
            if (bus.in_last) begin
              state_nxt = S_RAMP_DOWN;
              ramp_nxt  = '0;
            end else if (state == S_RAMP_UP) begin
              if (ramp_k == K_LAST) begin
                state_nxt = S_ON;
                ramp_nxt  = '0;
              end else begin
                ramp_nxt = ramp_k + 1'b1;
              end
            end
          end else begin
            // Starved: replay the held sample at the current gain, then fade out.
            starve    = 1'b1;
            sel_held  = 1'b1;
            state_nxt = S_RAMP_DOWN;
            ramp_nxt  = '0;
          end
        end
      end
      S_RAMP_DOWN: begin
        if (samp_en) begin
          sel_held = 1'b1;
          gain     = {1'b0, ~ramp_k};
          if (ramp_k == K_LAST) begin
            state_nxt = S_TAIL;
            tick_nxt  = 16'(TAIL_SAMPLES - 1);
            ramp_nxt  = '0;
          end else begin
            ramp_nxt = ramp_k + 1'b1;
          end
        end
      end
      S_TAIL: begin
        if (samp_en) begin
          if (tick_cnt == '0) begin
            state_nxt = S_IDLE;
          end else begin
            tick_nxt = tick_cnt - 16'd1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      ramp_k        <= '0;
      tick_cnt      <= '0;
      underflow     <= 1'b0;
      held_i        <= '0;
      held_q        <= '0;
      v1            <= 1'b0;
      bus.valid_out <= 1'b0;
    end else begin
      state         <= state_nxt;
      ramp_k        <= ramp_nxt;
      tick_cnt      <= tick_nxt;
      v1            <= samp_en;
      bus.valid_out <= v1;
      if (starve) underflow <= 1'b1;
      if (clear_held) begin
        held_i <= '0;
        held_q <= '0;
      end else if (pop) begin
        held_i <= bus.data_i_in;
        held_q <= bus.data_q_in;
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    samp_t x_i, x_q, y_i, y_q;
    assign x_i = sel_held ? held_i[c] : bus.data_i_in[c];
    assign x_q = sel_held ? held_q[c] : bus.data_q_in[c];

    ad9361_tx_ramp_mul #(.LOG2_RAMP_LEN(LOG2_RAMP_LEN)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .ld_prod (samp_en),
      .ld_out  (v1),
      .gain    (gain),
      .i_in    (x_i),
      .q_in    (x_q),
      .i_out   (y_i),
      .q_out   (y_q)
    );

    assign bus.data_i_out[c] = y_i;
    assign bus.data_q_out[c] = y_q;
  end

`ifdef AD9361_TX_BURST_STATS_EN
  logic        burst_done;
  logic [15:0] burst_cnt_q;
  logic [15:0] uf_cnt_q;

  assign burst_done = samp_en && (state == S_TAIL) && (tick_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_q <= '0;
      uf_cnt_q    <= '0;
    end else begin
      if (burst_done && (burst_cnt_q != 16'hFFFF)) burst_cnt_q <= burst_cnt_q + 16'd1;
      if (starve && (uf_cnt_q != 16'hFFFF))        uf_cnt_q    <= uf_cnt_q + 16'd1;
    end
  end

  assign burst_count     = burst_cnt_q;
  assign underflow_count = uf_cnt_q;
`else
  assign burst_count     = 16'd0;
  assign underflow_count = 16'd0;
`endif

endmodule
